instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/risc_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 84 ++++++++
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the fetch FSM encoding, the buffered entry layout and the PC increment helper.
package risc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StDiscard = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Word-address increment; wraps from all-ones back to zero.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: small circular FIFO of {instr, pc} entries with a synchronous clear.
// When empty, the head output keeps showing the last entry that was at the head.
module fetch_fifo
    import risc_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  fetch_entry_t    wdata_i,
    output fetch_entry_t    rdata_o,
    output logic            valid_o,
    output logic            full_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    last_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic empty;
    logic do_push;
    logic do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        empty   = (count_q == '0);
        full_o  = (count_q == DepthCnt);
        do_pop  = pop_i && !empty;
        do_push = push_i && (!full_o || do_pop);
        valid_o = !empty;
        count_o = count_q;
        rdata_o = empty ? last_q : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Track the visible head so it can be held once the buffer drains or is cleared.
            if (!empty) begin
                last_q <= mem_q[rd_ptr_q];
            end
            if (clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) begin
                    mem_q[wr_ptr_q] <= wdata_i;
                    wr_ptr_q        <= ptr_inc(wr_ptr_q);
                end
                if (do_pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + CntW'(1);
                    2'b01:   count_q <= count_q - CntW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single-beat memory reads into a prefetch buffer,
// with redirect (flush) support that discards buffered and in-flight fetches.
module instr_fetch
    import risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] incr_pc_i,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    fetch_state_e state_q;
    logic         req_q;
    logic [31:0]  addr_q;
    logic [31:0]  fetch_pc_q;

    fetch_entry_t    fifo_wdata;
    fetch_entry_t    fifo_head;
    logic            fifo_valid;
    logic            fifo_full;
    logic [CntW-1:0] fifo_count;

    logic          push;
    logic          pop;
    logic [CntW:0] count_after;
    logic          room_after;

    always_comb begin
        pop         = fifo_valid && instr_ready_i;
        push        = (state_q == StReq) && imem_ack_i && !flush_i;
        fifo_wdata  = '{instr: imem_rdata_i, pc: addr_q};
        count_after = {1'b0, fifo_count} + {{CntW{1'b0}}, push} - {{CntW{1'b0}}, pop};
        room_after  = count_after < {1'b0, DepthCnt};
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (reset_ni),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush_i),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .valid_o (fifo_valid),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // In StReq fetch_pc_q always equals the outstanding address; it only advances on a kept ack.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            addr_q     <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                StIdle: begin
                    if (flush_i) begin
                        fetch_pc_q <= incr_pc_i;
                    end else if (!fifo_full) begin
                        state_q <= StReq;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                StReq: begin
                    if (flush_i) begin
                        fetch_pc_q <= incr_pc_i;
                        if (imem_ack_i) begin
                            state_q <= StIdle;
                            req_q   <= 1'b0;
                        end else begin
                            state_q <= StDiscard;
                        end
                    end else if (imem_ack_i) begin
                        fetch_pc_q <= pc_next(fetch_pc_q);
                        if (room_after) begin
                            addr_q <= pc_next(fetch_pc_q);
                        end else begin
                            state_q <= StIdle;
                            req_q   <= 1'b0;
                        end
                    end
                end
                StDiscard: begin
                    if (flush_i) begin
                        fetch_pc_q <= incr_pc_i;
                    end
                    if (imem_ack_i) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_o       = fifo_head.instr;
    assign instr_pc_o    = fifo_head.pc;
    assign instr_valid_o = fifo_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed redirect/reset scenarios followed by
// random traffic, all compared against a queue-based reference model of the fetch rules.
module tb_instr_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] incr_pc;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: buffered words, one optional outstanding request, next address.
    logic [63:0] mq[$];
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic [31:0] m_last_instr;
    logic [31:0] m_last_pc;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (rst_n),
        .incr_pc_i     (incr_pc),
        .flush_i       (flush),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out        = 1'b0;
        m_drop       = 1'b0;
        m_addr       = '0;
        m_pc         = RESET_PC;
        m_last_instr = '0;
        m_last_pc    = '0;
    endtask

    // Apply this cycle's inputs to the model (called just before the rising edge).
    task automatic model_step();
        int cnt_before;
        bit pop;
        cnt_before = mq.size();
        pop        = (cnt_before > 0) && instr_ready;
        if (flush) begin
            mq.delete();
            m_pc = incr_pc;
            if (m_out) begin
                if (imem_ack) begin
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_out) begin
                if (imem_ack) begin
                    if (m_drop) begin
                        m_out  = 1'b0;
                        m_drop = 1'b0;
                    end else begin
                        mq.push_back({imem_rdata, m_addr});
                        m_pc = m_pc + 32'd1;
                        if (mq.size() < DEPTH) m_addr = m_pc;
                        else m_out = 1'b0;
                    end
                end
            end else if (cnt_before < DEPTH) begin
                m_out  = 1'b1;
                m_addr = m_pc;
            end
        end
        if (mq.size() > 0) {m_last_instr, m_last_pc} = mq[0];
    endtask

    task automatic compare();
        check("imem_req", 32'(imem_req), 32'(m_out));
        check("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
        if (m_out) check("imem_addr", imem_addr, m_addr);
        check("instr", instr, m_last_instr);
        check("instr_pc", instr_pc, m_last_pc);
    endtask

    task automatic drive(input bit ack, input bit rdy, input bit fl, input logic [31:0] inc);
        imem_ack    = ack;
        instr_ready = rdy;
        flush       = fl;
        incr_pc     = inc;
        imem_rdata  = mem_word(imem_addr);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    // Assert reset mid-cycle, check outputs before any clock edge, then release.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();
        #2;
        check({tag, "_req"}, 32'(imem_req), 32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_pc"}, instr_pc, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] inc;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();
        #2;
        check("por_req", 32'(imem_req), 32'h0);
        check("por_valid", 32'(instr_valid), 32'h0);
        check("por_addr", imem_addr, 32'h0);
        check("por_instr", instr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming: ack every cycle, decode always ready.
        for (int k = 1; k <= 5; k++) begin
            drive(m_out, 1'b1, 1'b0, 32'h0);
            cycle();
            check("stream_addr", imem_addr, 32'(k - 1));
            if (k >= 2) check("stream_pc", instr_pc, 32'(k - 2));
        end

        // Decode stalled: buffer fills after two fetches, then resumes at address 2.
        do_reset("rst_a");
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        check("stall_a0", imem_addr, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        check("stall_a1", imem_addr, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        check("stall_req_off", 32'(imem_req), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        check("stall_still_off", 32'(imem_req), 32'h0);
        check("stall_head", instr_pc, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        cycle();
        check("stall_head2", instr_pc, 32'h1);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        cycle();
        check("resume_req", 32'(imem_req), 32'h1);
        check("resume_addr", imem_addr, 32'h2);

        // Flush while a request is outstanding; its late ack must be dropped.
        do_reset("rst_b");
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        drive(1'b0, 1'b0, 1'b1, 32'h40);
        cycle();
        check("disc_req_held", 32'(imem_req), 32'h1);
        check("disc_addr_held", imem_addr, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        check("disc_drop_valid", 32'(instr_valid), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        check("redir_addr", imem_addr, 32'h40);
        check("redir_valid", 32'(instr_valid), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        check("redir_pc", instr_pc, 32'h40);
        check("redir_instr", instr, mem_word(32'h40));

        // Flush coincident with ack and pop.
        do_reset("rst_c");
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        drive(1'b1, 1'b1, 1'b1, 32'h100);
        cycle();
        check("fap_valid", 32'(instr_valid), 32'h0);
        check("fap_req", 32'(imem_req), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        check("fap_next_addr", imem_addr, 32'h100);

        // Redirect to the top of the address space; PC wraps to zero.
        do_reset("rst_d");
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        check("wrap_addr", imem_addr, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        check("wrap_addr0", imem_addr, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        check("wrap_pc_top", instr_pc, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        cycle();
        check("wrap_pc_zero", instr_pc, 32'h0);

        // Reset while requesting with data buffered; stray ack after release is ignored.
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        check("pre_rst_req", 32'(imem_req), 32'h1);
        check("pre_rst_valid", 32'(instr_valid), 32'h1);
        do_reset("rst_mid");
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        check("post_rst_addr", imem_addr, RESET_PC);
        check("post_rst_valid", 32'(instr_valid), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        check("post_rst_pc", instr_pc, RESET_PC);

        // Random traffic, including stray acks, stalls and wrap-adjacent redirects.
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0:       inc = 32'hFFFF_FFFE;
                1:       inc = 32'hFFFF_FFFF;
                default: inc = $urandom;
            endcase
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 15) == 0, inc);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
